// File: rtl/ps2_kbd_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_if
//   Scan-code event channel between the PS/2 receiver and its consumer.
//   The producer presents the head event of its FIFO and holds it until the
//   consumer takes it with code_valid & code_ready on a rising clock edge.
//
//   Signals
//     code_data   8  scan-code byte of the head event
//     code_ext    1  head event was preceded by an E0 prefix
//     code_rel    1  head event was preceded by an F0 (break) prefix
//     code_valid  1  an event is being presented
//     code_ready  1  consumer accepts the presented event
//
//   Modports
//     master  event producer (the receiver)
//     slave   event consumer (application logic)
// ---------------------------------------------------------------------------
interface ps2_kbd_rx_if;
    logic [7:0] code_data;
    logic       code_ext;
    logic       code_rel;
    logic       code_valid;
    logic       code_ready;

    modport master (
        output code_data,
        output code_ext,
        output code_rel,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_data,
        input  code_ext,
        input  code_rel,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
//   PS/2 keyboard receiver. Synchronises and de-glitches the raw PS/2 pins,
//   frames start/8 data/odd parity/stop, and queues the received scan codes
//   in a small show-ahead FIFO read through a valid/ready handshake.
//   Everything runs on the rising edge of app_clk.
//
//   Parameters
//     FILTER_LEN   consecutive equal samples before the filtered clock moves
//     TIMEOUT_CYC  idle cycles tolerated mid-frame before the frame is aborted
//     FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//
//   Ports
//     app_clk     in   clock
//     app_rst     in   synchronous active-high reset
//     ps2_clk     in   raw PS/2 clock pin (asynchronous)
//     ps2_data    in   raw PS/2 data pin (asynchronous)
//     code        ps2_kbd_rx_if.master event channel
//     err_parity  out  one-cycle pulse, parity error, byte dropped
//     err_frame   out  one-cycle pulse, bad stop bit or mid-frame timeout
//     overflow    out  one-cycle pulse, event dropped because FIFO was full
//
//   Build option
//     PS2_PREFIX_DECODE_EN  when defined, E0 and F0 bytes are folded into
//                           code_ext/code_rel of the next byte instead of
//                           being delivered as events.
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            app_clk,
    input  logic            app_rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_kbd_rx_if.master    code,
    output logic            err_parity,
    output logic            err_frame,
    output logic            overflow
);

    localparam int FILT_W = $clog2(FILTER_LEN);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Pin synchronisers; reset to the idle-high level of the bus.
    logic clk_s1_q, clk_s2_q;
    logic data_s1_q, data_s2_q;

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // The filtered clock only follows the synced clock once the new level has
    // been seen FILTER_LEN cycles in a row; any return to the current level
    // restarts the count, so shorter glitches never reach the edge detector.
    logic              clk_f_q, clk_f_d;
    logic              clk_f_prev_q;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

    always_comb begin
        clk_f_d    = clk_f_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_f_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                clk_f_d = clk_s2_q;
            end else begin
                filt_cnt_d = FILT_W'(filt_cnt_q + 1);
            end
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            clk_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
            filt_cnt_q   <= '0;
        end else begin
            clk_f_q      <= clk_f_d;
            clk_f_prev_q <= clk_f_q;
            filt_cnt_q   <= filt_cnt_d;
        end
    end

    // Falling edge of the filtered clock: the device holds data stable here.
    logic strobe;
    assign strobe = clk_f_prev_q & ~clk_f_q;

    // Frame receiver state and its registered outputs.
    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             ext_pend_q, rel_pend_q;
    logic             err_parity_q, err_frame_q;
    logic             push_q;
    logic [7:0]       push_data_q;
    logic             push_ext_q, push_rel_q;

    logic tmo_hit;
    logic parity_ok;

    assign tmo_hit   = (state_q != ST_IDLE) && !strobe &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    // Data plus parity must hold an odd number of ones.
    assign parity_ok = ^{shift_q, par_q};

    // Frame FSM. Bits arrive LSB first and are shifted in from the top, so
    // after eight strobes shift_q holds the byte in natural order. Errors and
    // timeouts drop the byte and forget any pending prefix so a stale E0/F0
    // cannot attach itself to an unrelated later key.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            ext_pend_q   <= 1'b0;
            rel_pend_q   <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            push_ext_q   <= 1'b0;
            push_rel_q   <= 1'b0;
        end else begin
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            push_q       <= 1'b0;

            if (state_q == ST_IDLE || strobe) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= TMO_W'(tmo_cnt_q + 1);
            end

            if (tmo_hit) begin
                state_q     <= ST_IDLE;
                err_frame_q <= 1'b1;
                ext_pend_q  <= 1'b0;
                rel_pend_q  <= 1'b0;
            end else if (strobe) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= data_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!data_s2_q) begin
                            err_frame_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            rel_pend_q  <= 1'b0;
                        end else if (!parity_ok) begin
                            err_parity_q <= 1'b1;
                            ext_pend_q   <= 1'b0;
                            rel_pend_q   <= 1'b0;
                        end else begin
`ifdef PS2_PREFIX_DECODE_EN
                            if (shift_q == 8'hE0) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                rel_pend_q <= 1'b1;
                            end else begin
                                push_q      <= 1'b1;
                                push_data_q <= shift_q;
                                push_ext_q  <= ext_pend_q;
                                push_rel_q  <= rel_pend_q;
                                ext_pend_q  <= 1'b0;
                                rel_pend_q  <= 1'b0;
                            end
`else
                            push_q      <= 1'b1;
                            push_data_q <= shift_q;
                            push_ext_q  <= ext_pend_q;
                            push_rel_q  <= rel_pend_q;
`endif
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Event FIFO. Pointers wrap naturally because the depth is a power of
    // two. When full, a same-cycle pop frees the head slot, which is exactly
    // the slot the write pointer addresses, so the push can still land.
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             fifo_valid, fifo_full, pop, wr_en;
    logic [9:0]       head;

    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = fifo_valid & code.code_ready;
    assign wr_en      = push_q & (!fifo_full | pop);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push_q & fifo_full & !pop;
        if (wr_en) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1);
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1);
        end
        if (wr_en && !pop) begin
            count_d = CNT_W'(count_q + 1);
        end else if (!wr_en && pop) begin
            count_d = CNT_W'(count_q - 1);
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge app_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {push_rel_q, push_ext_q, push_data_q};
        end
    end

    // Head fields are forced to zero while empty so idle outputs are clean.
    assign code.code_valid = fifo_valid;
    assign code.code_data  = fifo_valid ? head[7:0] : 8'h00;
    assign code.code_ext   = fifo_valid & head[8];
    assign code.code_rel   = fifo_valid & head[9];

    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
//   Drives PS/2 frames (shortened bit period) into ps2_kbd_rx. A reference
//   model of the keyboard protocol decides which events and error pulses each
//   frame should produce; a separate monitor consumes events from the DUT and
//   compares them against the expected queue.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 300;
   localparam int FIFO_DEPTH  = 4;
   localparam int HALF        = 20;

   typedef struct packed {
      logic [7:0] data;
      logic       ext;
      logic       rel;
   } event_t;

   logic app_clk  = 1'b0;
   logic app_rst  = 1'b1;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;
   logic err_parity, err_frame, overflow;

   ps2_kbd_rx_if code_if();

   ps2_kbd_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .app_clk    (app_clk),
      .app_rst    (app_rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code_if),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .overflow   (overflow)
   );

   // 25 MHz application clock
   always #20 app_clk = ~app_clk;

   event_t expQ[$];
   int checks = 0;
   int passes = 0;
   int expParity = 0, expFrame = 0, expOverflow = 0;
   int seenParity = 0, seenFrame = 0, seenOverflow = 0;
   int highParity = 0, highFrame = 0, highOverflow = 0;
   int readyMode = 0;
   int modelFill = 0;
   int cycle = 0;
   bit extPend = 1'b0;
   bit relPend = 1'b0;

   // Generic comparison with a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge app_clk);
   endtask

   // Expected outcome of one frame, from the protocol rules only
   task automatic deliver(input event_t e);
      if (readyMode == 0) begin
         if (modelFill == FIFO_DEPTH) begin
            expOverflow++;
         end else begin
            expQ.push_back(e);
            modelFill++;
         end
      end else begin
         expQ.push_back(e);
      end
   endtask

   task automatic modelFrame(input logic [7:0] b, input bit parErr, input bit stopErr);
      event_t e;
      if (stopErr) begin
         expFrame++;
         extPend = 1'b0;
         relPend = 1'b0;
      end else if (parErr) begin
         expParity++;
         extPend = 1'b0;
         relPend = 1'b0;
      end else begin
`ifdef PS2_PREFIX_DECODE_EN
         if (b == 8'hE0) begin
            extPend = 1'b1;
         end else if (b == 8'hF0) begin
            relPend = 1'b1;
         end else begin
            e.data = b;
            e.ext  = extPend;
            e.rel  = relPend;
            deliver(e);
            extPend = 1'b0;
            relPend = 1'b0;
         end
`else
         e.data = b;
         e.ext  = 1'b0;
         e.rel  = 1'b0;
         deliver(e);
`endif
      end
   endtask

   // Pin-level frame: first nbits of start, data LSB first, parity, stop
   task automatic sendFrame(input logic [7:0] b, input bit parErr, input bit stopErr,
                            input int nbits);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = (~^b) ^ parErr;
      bits[10]  = ~stopErr;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         waitCycles(HALF);
         ps2_clk = 1'b0;
         waitCycles(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      waitCycles(2 * HALF);
   endtask

   // Model first, so the expectation exists before the DUT can present it
   task automatic applyStimulus(input logic [7:0] b, input bit parErr, input bit stopErr);
      modelFrame(b, parErr, stopErr);
      sendFrame(b, parErr, stopErr, 11);
   endtask

   task automatic checkErrors(input string tag);
      checkOutput({tag, "_err_parity_count"}, seenParity, expParity);
      checkOutput({tag, "_err_frame_count"}, seenFrame, expFrame);
      checkOutput({tag, "_overflow_count"}, seenOverflow, expOverflow);
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         waitCycles(1);
         n++;
      end
      waitCycles(3);
      checkOutput({tag, "_drain_pending"}, expQ.size(), 0);
      checkOutput({tag, "_drain_valid"}, code_if.code_valid, 1'b0);
      modelFill = 0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_code_valid"}, code_if.code_valid, 1'b0);
      checkOutput({tag, "_code_data"}, code_if.code_data, 8'h00);
      checkOutput({tag, "_code_ext"}, code_if.code_ext, 1'b0);
      checkOutput({tag, "_code_rel"}, code_if.code_rel, 1'b0);
      checkOutput({tag, "_err_parity"}, err_parity, 1'b0);
      checkOutput({tag, "_err_frame"}, err_frame, 1'b0);
      checkOutput({tag, "_overflow"}, overflow, 1'b0);
   endtask

   // Monitor: drives ready, consumes events, counts error pulses
   initial begin
      bit prevParity, prevFrame, prevOverflow;
      event_t e;
      prevParity   = 1'b0;
      prevFrame    = 1'b0;
      prevOverflow = 1'b0;
      code_if.code_ready = 1'b0;
      forever begin
         @(negedge app_clk);
         cycle++;
         if (cycle > 150000) begin
            $display("[TB] FAIL watchdog: cycle %0d, limit 150000", cycle);
            $fatal(1, "[TB] watchdog expired");
         end
         if (readyMode == 2) begin
            code_if.code_ready = ($urandom_range(0, 1) == 1);
         end else begin
            code_if.code_ready = (readyMode == 1);
         end
         if (!app_rst && code_if.code_valid && code_if.code_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               $display("[TB] FAIL unexpected_event: got data 0x%0h, expected no event",
                        code_if.code_data);
            end else begin
               e = expQ.pop_front();
               checkOutput("evt_data", code_if.code_data, e.data);
               checkOutput("evt_ext", code_if.code_ext, e.ext);
               checkOutput("evt_rel", code_if.code_rel, e.rel);
            end
         end
         if (err_parity) highParity++;
         if (err_frame) highFrame++;
         if (overflow) highOverflow++;
         if (err_parity && !prevParity) seenParity++;
         if (err_frame && !prevFrame) seenFrame++;
         if (overflow && !prevOverflow) seenOverflow++;
         prevParity   = err_parity;
         prevFrame    = err_frame;
         prevOverflow = overflow;
      end
   end

   initial begin
      logic [7:0] b;
      bit pe, se;
      int r;

      // Reset state
      app_rst = 1'b1;
      waitCycles(5);
      checkIdleOutputs("reset");
      app_rst = 1'b0;
      waitCycles(50);

      // Single event held until accepted
      $display("[TB] basic frame 1C");
      readyMode = 0;
      modelFill = 0;
      applyStimulus(8'h1C, 1'b0, 1'b0);
      checkOutput("t1_valid_held", code_if.code_valid, 1'b1);
      checkOutput("t1_head_data", code_if.code_data, 8'h1C);
      waitCycles(100);
      checkOutput("t1_valid_still", code_if.code_valid, 1'b1);
      readyMode = 1;
      waitDrain("t1");
      checkErrors("t1");

      // Prefix sequence
      $display("[TB] prefix sequence E0 F0 75");
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b0);
      waitDrain("t2");
      checkErrors("t2");

      // Parity error, pending prefix dropped by error, recovery
      $display("[TB] parity and stop errors");
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b1, 1'b0);
      applyStimulus(8'h29, 1'b0, 1'b0);
      applyStimulus(8'h33, 1'b0, 1'b1);
      applyStimulus(8'h34, 1'b1, 1'b1);
      applyStimulus(8'h5A, 1'b0, 1'b0);
      waitDrain("t3");
      checkErrors("t3");

      // Truncated frame followed by idle clock
      $display("[TB] mid-frame timeout");
      expFrame++;
      extPend = 1'b0;
      relPend = 1'b0;
      sendFrame(8'h15, 1'b0, 1'b0, 6);
      waitCycles(TIMEOUT_CYC + 100);
      checkErrors("t4_timeout");
      applyStimulus(8'h29, 1'b0, 1'b0);
      waitDrain("t4");
      checkErrors("t4");

      // Overflow with consumer stalled
      $display("[TB] FIFO overflow");
      readyMode = 0;
      modelFill = 0;
      applyStimulus(8'h16, 1'b0, 1'b0);
      applyStimulus(8'h1E, 1'b0, 1'b0);
      applyStimulus(8'h26, 1'b0, 1'b0);
      applyStimulus(8'h25, 1'b0, 1'b0);
      applyStimulus(8'h2E, 1'b0, 1'b0);
      checkOutput("t5_valid_full", code_if.code_valid, 1'b1);
      checkErrors("t5_full");
      readyMode = 1;
      waitDrain("t5");

      // Short clock glitch with data low must not start a frame
      $display("[TB] clock glitch");
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      waitCycles(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      waitCycles(10);
      ps2_data = 1'b1;
      waitCycles(40);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      waitDrain("t6");
      checkErrors("t6");

      // Reset in the middle of a frame with an event queued
      $display("[TB] reset mid-frame");
      readyMode = 0;
      modelFill = 0;
      applyStimulus(8'h4D, 1'b0, 1'b0);
      sendFrame(8'h6B, 1'b0, 1'b0, 4);
      app_rst = 1'b1;
      waitCycles(1);
      checkIdleOutputs("midrst");
      app_rst = 1'b0;
      expQ.delete();
      modelFill = 0;
      extPend = 1'b0;
      relPend = 1'b0;
      waitCycles(50);
      readyMode = 1;
      applyStimulus(8'h1C, 1'b0, 1'b0);
      waitDrain("t7");
      checkErrors("t7");

      // Randomised traffic with random consumer back-pressure
      $display("[TB] random traffic");
      readyMode = 2;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         else b = 8'($urandom_range(0, 255));
         pe = ($urandom_range(0, 9) == 0);
         se = ($urandom_range(0, 14) == 0);
         applyStimulus(b, pe, se);
      end
      readyMode = 1;
      waitDrain("rand");
      checkErrors("rand");

      // Error strobes must each be exactly one cycle wide
      checkOutput("err_parity_width", highParity, seenParity);
      checkOutput("err_frame_width", highFrame, seenFrame);
      checkOutput("overflow_width", highOverflow, seenOverflow);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
